// File: rtl/addr_bus_unit.sv
// addr_bus_unit
// -------------
// Address bus register pair {ABH, ABL} with a simple burst incrementer.
// In IDLE, ABL/ABH load independently from ADL/ADH. ABL loads can force
// individual low bits to zero. A burst request with a non-zero length
// latches the length and the wrap mode. The unit then steps the address
// once per enabled cycle until the length is used up.
//
// RDY works as a global enable, not as a two-sided handshake. When RDY=1,
// the current inputs are acted on at the next rising edge. When RDY=0,
// every register holds its value except DONE and CARRY. Those two are
// one-cycle pulses, so they always clear on the next edge.
//
// Ports
//   CLK        in   clock, rising edge
//   n_RES      in   asynchronous active-low reset
//   RDY        in   update enable
//   ADL        in   [LW-1:0]    low address bus value
//   ADH        in   [AW-LW-1:0] high address bus value
//   Z_ADL      in   [ZW-1:0]    per-bit force-zero of ABL[ZW-1:0] on load
//   ADL_ABL    in   load enable for ABL
//   ADH_ABH    in   load enable for ABH
//   BURST      in   burst start request
//   BLEN       in   [LENW-1:0]  number of increments in the burst
//   PAGE_WRAP  in   1: wrap within ABL only, 0: full-width increment
//   AB         out  [AW-1:0]    registered address {ABH, ABL}
//   BUSY       out  burst in progress
//   DONE       out  one-cycle burst completion pulse
//   CARRY      out  one-cycle pulse after ABL wrapped during a burst step
//   dbg_state  out  FSM state (0 = IDLE, 1 = BURST)
module addr_bus_unit #(
    parameter int AW   = 16,
    parameter int LW   = 8,
    parameter int ZW   = 3,
    parameter int LENW = 4
) (
    input  logic              CLK,
    input  logic              n_RES,
    input  logic              RDY,
    input  logic [LW-1:0]     ADL,
    input  logic [AW-LW-1:0]  ADH,
    input  logic [ZW-1:0]     Z_ADL,
    input  logic              ADL_ABL,
    input  logic              ADH_ABH,
    input  logic              BURST,
    input  logic [LENW-1:0]   BLEN,
    input  logic              PAGE_WRAP,
    output logic [AW-1:0]     AB,
    output logic              BUSY,
    output logic              DONE,
    output logic              CARRY,
    output logic              dbg_state
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [LW-1:0]    ABL_ONE = LW'(1);
    localparam logic [AW-LW-1:0] ABH_ONE = (AW - LW)'(1);
    localparam logic [LENW-1:0]  CNT_ONE = LENW'(1);

    state_t            state;
    logic [LW-1:0]     abl;
    logic [AW-LW-1:0]  abh;
    logic [LENW-1:0]   cnt;
    logic              mode;
    logic              done_q;
    logic              carry_q;

    // Only the low ZW bits of ABL can be forced to zero. Upper mask bits stay 0.
    logic [LW-1:0]     zmask;

    always_comb begin
        zmask          = '0;
        zmask[ZW-1:0]  = Z_ADL;
    end

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            state   <= ST_IDLE;
            abl     <= '0;
            abh     <= '0;
            cnt     <= '0;
            mode    <= 1'b0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            // Pulses last exactly one cycle, whatever RDY does.
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            if (RDY) begin
                case (state)
                    ST_IDLE: begin
                        // Loads in the start cycle form the burst base address.
                        if (ADL_ABL) abl <= ADL & ~zmask;
                        if (ADH_ABH) abh <= ADH;
                        if (BURST) begin
                            if (BLEN != '0) begin
                                cnt   <= BLEN;
                                mode  <= PAGE_WRAP;
                                state <= ST_BURST;
                            end else begin
                                // A zero-length burst completes at once.
                                done_q <= 1'b1;
                            end
                        end
                    end
                    ST_BURST: begin
                        // Load and start requests are ignored here.
                        abl     <= abl + ABL_ONE;
                        carry_q <= &abl;
                        // Page-wrap mode keeps ABH fixed. Otherwise an ABL
                        // wrap carries into ABH.
                        if (!mode && (&abl)) abh <= abh + ABH_ONE;
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign AB        = {abh, abl};
    assign BUSY      = (state == ST_BURST);
    assign DONE      = done_q;
    assign CARRY     = carry_q;
    assign dbg_state = state;

endmodule
